// File: rtl/reg_bank_pkg.sv
// Shared types and default sizing for the register-bank arbiter slice.
// Optional build macro used by this slice: REG_BANK_PRIO0_EN.
package reg_bank_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } reg_bank_state_t;

  localparam int NUM_REQ_DEF  = 4;
  localparam int NUM_REGS_DEF = 8;
  localparam int DATA_W_DEF   = 8;

endpackage : reg_bank_pkg

// File: rtl/rr_arbiter.sv
// Round-robin winner selection over the write requests, holding the last_win pointer.
// Macro REG_BANK_PRIO0_EN: requester 0 always wins and does not move the pointer.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               take,
  output logic [NUM_REQ-1:0] win,
  output logic [IDX_W-1:0]   win_idx,
  output logic               any_req
);

  logic [IDX_W-1:0] last_win_r;
  logic             upd_ok_s;
  logic             found_s;
  int               idx_s;

  // Search requests starting just after the last winner, wrapping modulo NUM_REQ.
  always_comb begin
    win     = '0;
    win_idx = '0;
    found_s = 1'b0;
    idx_s   = 0;
    any_req = |req;
`ifdef REG_BANK_PRIO0_EN
    if (req[0]) begin
      win[0]  = 1'b1;
      found_s = 1'b1;
    end else begin
      found_s = 1'b0;
    end
`endif
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx_s = (int'(last_win_r) + k) % NUM_REQ;
      if (!found_s && req[idx_s]) begin
        win[idx_s] = 1'b1;
        win_idx    = IDX_W'(idx_s);
        found_s    = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

`ifdef REG_BANK_PRIO0_EN
  assign upd_ok_s = ~win[0];
`else
  assign upd_ok_s = 1'b1;
`endif

  // Pointer advances only when the top actually commits to a winner.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_win_r <= IDX_W'(NUM_REQ - 1);
    end else if (take && upd_ok_s) begin
      last_win_r <= win_idx;
    end else begin
      last_win_r <= last_win_r;
    end
  end

endmodule : rr_arbiter

// File: rtl/reg_bank_arbiter.sv
// Register bank shared by NUM_REQ writers: arbitrate, capture, commit one write per grant.
// Macro REG_BANK_PRIO0_EN gives requester 0 fixed highest priority (handled in rr_arbiter).
module reg_bank_arbiter
  import reg_bank_pkg::*;
#(
  parameter int NUM_REQ  = NUM_REQ_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       wr_err,
  output logic                       busy,
  input  logic [ADDR_W-1:0]          rd_addr,
  output logic [DATA_W-1:0]          rd_data
);

  localparam int             IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_W:0] REGS_LIM = (ADDR_W + 1)'(NUM_REGS);

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < REGS_LIM);
  endfunction

  reg_bank_state_t     state_r;
  logic [NUM_REQ-1:0]  gnt_r;
  logic                wr_err_r;
  logic                busy_r;
  logic [ADDR_W-1:0]   cap_addr_r;
  logic [DATA_W-1:0]   cap_data_r;
  logic [DATA_W-1:0]   regs_r [NUM_REGS];
  logic [DATA_W-1:0]   rd_data_r;

  logic [NUM_REQ-1:0]  win_s;
  logic [IDX_W-1:0]    win_idx_s;
  logic                any_req_s;
  logic                take_s;
  logic                wr_en_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [DATA_W-1:0]   sel_data_s;

  assign take_s  = (state_r == IDLE) && any_req_s;
  assign wr_en_s = (state_r == WRITE) && addr_ok(cap_addr_r);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .take    (take_s),
    .win     (win_s),
    .win_idx (win_idx_s),
    .any_req (any_req_s)
  );

  // One-hot AND-OR mux of the winner's address and data slices.
  always_comb begin
    sel_addr_s = '0;
    sel_data_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_addr_s = sel_addr_s | (req_addr[i*ADDR_W +: ADDR_W] & {ADDR_W{win_s[i]}});
      sel_data_s = sel_data_s | (req_data[i*DATA_W +: DATA_W] & {DATA_W{win_s[i]}});
    end
  end

  // Two-state FSM; gnt/busy/wr_err are loaded at the arbitration edge so they cover WRITE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      gnt_r      <= '0;
      wr_err_r   <= 1'b0;
      busy_r     <= 1'b0;
      cap_addr_r <= '0;
      cap_data_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            state_r    <= WRITE;
            gnt_r      <= win_s;
            busy_r     <= 1'b1;
            wr_err_r   <= ~addr_ok(sel_addr_s);
            cap_addr_r <= sel_addr_s;
            cap_data_r <= sel_data_s;
          end else begin
            state_r    <= IDLE;
            gnt_r      <= '0;
            busy_r     <= 1'b0;
            wr_err_r   <= 1'b0;
            cap_addr_r <= cap_addr_r;
            cap_data_r <= cap_data_r;
          end
        end
        WRITE: begin
          state_r    <= IDLE;
          gnt_r      <= '0;
          busy_r     <= 1'b0;
          wr_err_r   <= 1'b0;
          cap_addr_r <= cap_addr_r;
          cap_data_r <= cap_data_r;
        end
        default: begin
          state_r    <= IDLE;
          gnt_r      <= '0;
          busy_r     <= 1'b0;
          wr_err_r   <= 1'b0;
          cap_addr_r <= '0;
          cap_data_r <= '0;
        end
      endcase
    end
  end

  // Storage commits on the edge that closes WRITE; out-of-range writes are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_r[r] <= '0;
      end
    end else if (wr_en_s) begin
      regs_r[cap_addr_r] <= cap_data_r;
    end else begin
      regs_r <= regs_r;
    end
  end

  // Registered read sees the pre-write value when read and write hit the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_r <= '0;
    end else if (addr_ok(rd_addr)) begin
      rd_data_r <= regs_r[rd_addr];
    end else begin
      rd_data_r <= '0;
    end
  end

  assign gnt     = gnt_r;
  assign wr_err  = wr_err_r;
  assign busy    = busy_r;
  assign rd_data = rd_data_r;

endmodule : reg_bank_arbiter

// File: tb/tb_reg_bank_arbiter.sv
// Self-checking bench for reg_bank_arbiter (NUM_REQ=4, NUM_REGS=6, DATA_W=8).
// Honours REG_BANK_PRIO0_EN when computing expected grant order.
module tb_reg_bank_arbiter;

  localparam int NR = 4;
  localparam int NG = 6;
  localparam int DW = 8;
  localparam int AW = 3;

  logic            clk;
  logic            rst;
  logic [NR-1:0]   req;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   gnt;
  logic            wr_err;
  logic            busy;
  logic [AW-1:0]   rd_addr;
  logic [DW-1:0]   rd_data;

  reg_bank_arbiter #(.NUM_REQ(NR), .NUM_REGS(NG), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
    .gnt(gnt), .wr_err(wr_err), .busy(busy), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NR-1:0]    req;
    logic [NR*AW-1:0] addrs;
    logic [NR*DW-1:0] datas;
    logic [NR-1:0]    exp_gnt;
    logic             exp_err;
  } vec_t;

  typedef struct packed {
    logic [NR-1:0] gnt;
    logic          err;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  vec_t          tbl [8];
  exp_t          sbq [$];
  logic [DW-1:0] mem [NG];
  int            tests;
  int            fails;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [NR-1:0] g, input logic err);
    exp_t e;
    int   wi;
    wi = 0;
    for (int j = 0; j < NR; j++) if (g[j]) wi = j;
    e.gnt  = g;
    e.err  = err;
    e.addr = req_addr[wi*AW +: AW];
    e.data = req_data[wi*DW +: DW];
    sbq.push_back(e);
  endtask

  task automatic wait_gnt(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (gnt == '0 && lat < 8);
    if (gnt == '0) check("gnt_timeout", 32'(gnt), 32'hF);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(gnt), 32'h0);
    end else begin
      e = sbq.pop_front();
      check({tag, "_gnt"}, 32'(gnt), 32'(e.gnt));
      check({tag, "_err"}, 32'(wr_err), 32'(e.err));
      check({tag, "_busy"}, 32'(busy), 32'h1);
      if (!e.err && e.addr < AW'(NG)) mem[e.addr] = e.data;
    end
  endtask

  task automatic readback(input string tag);
    for (int a = 0; a < 8; a++) begin
      rd_addr = AW'(a);
      @(negedge clk);
      check($sformatf("%s_rd%0d", tag, a), 32'(rd_data), (a < NG) ? 32'(mem[a]) : 32'h0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    logic [DW-1:0] old;
    exp_t pending [$];
    tests = 0;
    fails = 0;
    for (int r = 0; r < NG; r++) mem[r] = 8'h00;

    // addrs/datas listed {req3, req2, req1, req0}; non-winners carry decoys.
    tbl[0] = '{4'b0100, {3'd0, 3'd3, 3'd1, 3'd2}, {8'h01, 8'hA5, 8'h02, 8'h03}, 4'b0100, 1'b0};
    tbl[1] = '{4'b1010, {3'd5, 3'd0, 3'd4, 3'd0}, {8'h5A, 8'h00, 8'hEE, 8'h00}, 4'b1000, 1'b0};
    tbl[2] = '{4'b1010, {3'd5, 3'd0, 3'd1, 3'd0}, {8'hDD, 8'h00, 8'h11, 8'h00}, 4'b0010, 1'b0};
    tbl[3] = '{4'b0110, {3'd0, 3'd7, 3'd3, 3'd0}, {8'h00, 8'hFF, 8'hBB, 8'h00}, 4'b0100, 1'b1};
    tbl[4] = '{4'b0010, {3'd0, 3'd0, 3'd0, 3'd0}, {8'h00, 8'h00, 8'hC3, 8'h00}, 4'b0010, 1'b0};
    tbl[5] = '{4'b1110, {3'd2, 3'd4, 3'd1, 3'd0}, {8'hAA, 8'h44, 8'hBB, 8'h00}, 4'b0100, 1'b0};
    tbl[6] = '{4'b0001, {3'd0, 3'd0, 3'd0, 3'd2}, {8'h00, 8'h00, 8'h00, 8'h22}, 4'b0001, 1'b0};
    tbl[7] = '{4'b0010, {3'd0, 3'd0, 3'd6, 3'd0}, {8'h00, 8'h00, 8'h66, 8'h00}, 4'b0010, 1'b1};

    rst = 1'b0; req = '0; req_addr = '0; req_data = '0; rd_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_err", 32'(wr_err), 32'h0);
    check("rst_rd", 32'(rd_data), 32'h0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      req = tbl[i].req; req_addr = tbl[i].addrs; req_data = tbl[i].datas;
      push_exp(tbl[i].exp_gnt, tbl[i].exp_err);
      wait_gnt(lat);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'h1);
      pop_check($sformatf("vec%0d", i));
      req_addr = ~req_addr; req_data = ~req_data; req = '0;
      @(negedge clk);
      check($sformatf("vec%0d_pulse", i), 32'({gnt, busy, wr_err}), 32'h0);
    end
    readback("tbl");

    // Same-edge read and write of register 2 returns the old value first.
    rd_addr = 3'd2;
    @(negedge clk);
    old = mem[2];
    check("rbw_pre", 32'(rd_data), 32'(old));
    req = 4'b0100; req_addr = {3'd0, 3'd2, 3'd0, 3'd0}; req_data = {8'h00, 8'h3C, 8'h00, 8'h00};
    push_exp(4'b0100, 1'b0);
    wait_gnt(lat);
    pop_check("rbw");
    req = '0;
    @(negedge clk);
    check("rbw_old", 32'(rd_data), 32'(old));
    @(negedge clk);
    check("rbw_new", 32'(rd_data), 32'h3C);

    // Asynchronous reset in the middle of WRITE aborts the commit.
    req = 4'b0001; req_addr = {3'd0, 3'd0, 3'd0, 3'd5}; req_data = {8'h00, 8'h00, 8'h00, 8'h99};
    wait_gnt(lat);
    check("mid_gnt", 32'(gnt), 32'h1);
    rst = 1'b0;
    #1;
    check("mid_rst_gnt", 32'(gnt), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_err", 32'(wr_err), 32'h0);
    check("mid_rst_rd", 32'(rd_data), 32'h0);
    req = '0;
    @(negedge clk);
    rst = 1'b1;
    for (int r = 0; r < NG; r++) mem[r] = 8'h00;
    readback("mid");

    // Continuous requests: grants every two cycles in rotation.
    req = 4'b1111; req_addr = {3'd3, 3'd2, 3'd1, 3'd0}; req_data = {8'h13, 8'h12, 8'h11, 8'h10};
`ifdef REG_BANK_PRIO0_EN
    for (int k = 0; k < 5; k++) push_exp(4'b0001, 1'b0);
`else
    push_exp(4'b0001, 1'b0); push_exp(4'b0010, 1'b0); push_exp(4'b0100, 1'b0);
    push_exp(4'b1000, 1'b0); push_exp(4'b0001, 1'b0);
`endif
    for (int k = 0; k < 5; k++) begin
      wait_gnt(lat);
      check($sformatf("fair%0d_lat", k), 32'(lat), (k == 0) ? 32'h1 : 32'h2);
      pop_check($sformatf("fair%0d", k));
    end
    req = 4'b1110;
    push_exp(4'b0010, 1'b0); push_exp(4'b0100, 1'b0); push_exp(4'b1000, 1'b0);
    for (int k = 0; k < 3; k++) begin
      wait_gnt(lat);
      check($sformatf("rot%0d_lat", k), 32'(lat), 32'h2);
      pop_check($sformatf("rot%0d", k));
    end
    req = '0;
    @(negedge clk);
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'h0);
    readback("fair");
    check("sb_drain", 32'(sbq.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_reg_bank_arbiter

// File: doc/reg_bank_arbiter.md
Name: reg_bank_arbiter

Overview:
- Shares one bank of D-flip-flop data registers between NUM_REQ write requesters using round-robin arbitration.
- Commits one write per grant and exposes a registered read port.
- Sits between the requesting units and the register storage, and is the only writer of that storage.

Parameters:
- NUM_REQ, 4, number of write requesters (2..8)
- NUM_REGS, 8, number of registers in the bank (need not be a power of 2)
- DATA_W, 8, register width in bits
- ADDR_W, $clog2(NUM_REGS), register address width

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  per-requester write request, level held until granted
- req_addr  in  NUM_REQ*ADDR_W  packed target addresses; requester i occupies slice i
- req_data  in  NUM_REQ*DATA_W  packed write data; requester i occupies slice i
- gnt  out  NUM_REQ  one-hot, single-cycle write-commit pulse
- wr_err  out  1  single-cycle pulse; the granted address was >= NUM_REGS
- busy  out  1  high while state is WRITE
- rd_addr  in  ADDR_W  read address
- rd_data  out  DATA_W  registered read data

Behaviour:
- Reset (rst low, asynchronous, may occur at any time):
  - state = IDLE; gnt = 0; wr_err = 0; busy = 0; rd_data = 0.
  - All registers = 0; round-robin pointer last_win = NUM_REQ-1, so requester 0 has highest priority first.
  - A reset mid-WRITE aborts the write: no register changes and no gnt pulse.
- States: IDLE, WRITE.
- IDLE:
  - If any req bit is high, select the winner = first requester set in the order last_win+1, last_win+2, … with wrap modulo NUM_REQ.
  - Capture the winner's addr and data into internal latches on that edge; set last_win = winner; go to WRITE.
  - If no req bit is high, stay in IDLE.
- WRITE (exactly one cycle):
  - gnt[winner] = 1 and busy = 1 for this cycle.
  - On the closing edge, if captured addr < NUM_REGS, then reg[addr] = captured data; otherwise the write is dropped and wr_err = 1 for this cycle.
  - Always return to IDLE; requests are not re-sampled in WRITE.
- Timing:
  - req sampled high at edge t: gnt high in cycle t+1; register updated at edge t+2.
  - Sustained throughput is one write per 2 cycles.
- Requester rules:
  - Hold req, addr and data stable until gnt is seen.
  - Changes to addr/data after the arbitration edge are ignored.
  - Deassert req, or present the next write, in the cycle after gnt. A req still high after gnt is treated as a new request.
- Read port:
  - rd_data = reg[rd_addr], registered with 1-cycle latency.
  - Read and write to the same address on the same edge return the old value (read-before-write).
  - rd_addr >= NUM_REGS returns 0.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,…,NUM_REQ-1,0,… and no requester waits more than NUM_REQ grants.

Optional Feature:
- Macro: REG_BANK_PRIO0_EN.
- Defined: requester 0 is fixed highest priority. If req[0] is high in IDLE it wins regardless of the pointer, and last_win is not updated on a requester-0 win. The remaining requesters rotate round-robin among themselves.
- Undefined: pure round-robin as described in Behaviour.

Decomposition:
- Package reg_bank_pkg:
  - state enum typedef reg_bank_state_t {IDLE, WRITE}.
  - Default constants for NUM_REQ, NUM_REGS and DATA_W.
- Sub-module rr_arbiter:
  - Holds the last_win pointer.
  - Combinational priority rotate over req, producing a one-hot winner plus an any_req flag.
  - The top level owns the FSM, capture latches, register array and read port.

Test Plan:
- Reset: drive registers non-zero, assert rst mid-WRITE → gnt=0, busy=0, all regs read 0, rd_data=0 immediately (asynchronous).
- Single request: req=4'b0100, addr=3, data=8'hA5 → gnt=4'b0100 one cycle later for 1 cycle; rd_addr=3 returns 8'hA5 after commit.
- All requesting continuously with distinct data → grant order 0,1,2,3,0 on consecutive WRITE cycles, each register holds its owner's data.
- Out-of-range: NUM_REGS=6, addr=7 → gnt pulses, wr_err=1 for the same cycle, no register changes.
- Same-address read/write: rd_addr=2 while a write of 8'h3C to reg 2 commits → rd_data shows old value, then 8'h3C on the next cycle.
- REG_BANK_PRIO0_EN defined, req=4'b1111 held → requester 0 wins every arbitration. Dropping req[0] → requesters 1,2,3 rotate.
